// File: rtl/sram_dual_port_ctrl.sv
// Dual-port SRAM controller: port 0 read/write with byte masks, port 1 read-only, zero-fill after reset and on clear.
// Read latency 1 cycle; a port stalls while clearing, during a clear pulse, or while its response is held by the consumer.
module sram_dual_port_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_MASKS  = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  clear,
  output logic                  busy,
  input  logic                  p0_valid,
  output logic                  p0_ready,
  input  logic                  p0_we,
  input  logic [NUM_MASKS-1:0]  p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  input  logic                  p0_rready,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_valid,
  output logic                  p1_ready,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic                  p1_rvalid,
  input  logic                  p1_rready,
  output logic [DATA_WIDTH-1:0] p1_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic p0_acc;
  logic p1_acc;
  logic p0_wr;
  logic p0_rd;

  // Ready never looks at valid, so masters may wait on ready before asserting valid.
  assign p0_ready = (state == ST_IDLE) && !clear && (!p0_rvalid || p0_rready);
  assign p1_ready = (state == ST_IDLE) && !clear && (!p1_rvalid || p1_rready);

  assign p0_acc = p0_valid && p0_ready;
  assign p1_acc = p1_valid && p1_ready;
  assign p0_wr  = p0_acc && p0_we;
  assign p0_rd  = p0_acc && !p0_we;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state <= ST_CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        default: begin
          state <= ST_CLEAR;
          cnt   <= '0;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  // Storage has no reset; the zero-fill sequence that follows reset initialises it.
  always_ff @(posedge clk0) begin
    if (!rst0) begin
      if (state == ST_CLEAR) begin
        mem[cnt] <= '0;
      end else if (p0_wr) begin
        for (int i = 0; i < NUM_MASKS; i++) begin
          if (p0_wmask[i]) begin
            mem[p0_addr][8*i +: 8] <= p0_wdata[8*i +: 8];
          end
        end
      end
    end
  end

  // Reads sample the array with the same edge's write still pending, giving read-before-write on port 1.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      p0_rvalid <= 1'b0;
      p0_rdata  <= '0;
    end else if (p0_rd) begin
      p0_rvalid <= 1'b1;
      p0_rdata  <= mem[p0_addr];
    end else if (p0_rready) begin
      p0_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      p1_rvalid <= 1'b0;
      p1_rdata  <= '0;
    end else if (p1_acc) begin
      p1_rvalid <= 1'b1;
      p1_rdata  <= mem[p1_addr];
    end else if (p1_rready) begin
      p1_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sram_dual_port_ctrl.sv
// Directed bench for sram_dual_port_ctrl: clear timing, masked writes, collisions, backpressure, clear and reset mid-flight.
module tb_sram_dual_port_ctrl;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        clear;
  logic        busy;
  logic        p0_valid;
  logic        p0_ready;
  logic        p0_we;
  logic [3:0]  p0_wmask;
  logic [7:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_rvalid;
  logic        p0_rready;
  logic [31:0] p0_rdata;
  logic        p1_valid;
  logic        p1_ready;
  logic [7:0]  p1_addr;
  logic        p1_rvalid;
  logic        p1_rready;
  logic [31:0] p1_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk0 = ~clk0;

  sram_dual_port_ctrl dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .clear     (clear),
    .busy      (busy),
    .p0_valid  (p0_valid),
    .p0_ready  (p0_ready),
    .p0_we     (p0_we),
    .p0_wmask  (p0_wmask),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_rvalid (p0_rvalid),
    .p0_rready (p0_rready),
    .p0_rdata  (p0_rdata),
    .p1_valid  (p1_valid),
    .p1_ready  (p1_ready),
    .p1_addr   (p1_addr),
    .p1_rvalid (p1_rvalid),
    .p1_rready (p1_rready),
    .p1_rdata  (p1_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a sample point #1 after a rising edge.
  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic wait_p0_ready(input string tag);
    int n = 0;
    while (!p0_ready && n < 1000) begin
      n++;
      tick();
    end
    check_eq(tag, {31'd0, p0_ready}, 32'd1);
  endtask

  task automatic wait_p1_ready(input string tag);
    int n = 0;
    while (!p1_ready && n < 1000) begin
      n++;
      tick();
    end
    check_eq(tag, {31'd0, p1_ready}, 32'd1);
  endtask

  task automatic p0_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_wmask = m;
    wait_p0_ready("p0_wr_ready");
    tick();
    p0_valid = 1'b0; p0_we = 1'b0; p0_wmask = 4'h0;
  endtask

  // Returns the data and whether rvalid was up exactly one cycle after accept.
  task automatic p0_read(input logic [7:0] a, output logic [31:0] d, output logic lat_ok);
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = a;
    wait_p0_ready("p0_rd_ready");
    tick();
    p0_valid = 1'b0;
    lat_ok = p0_rvalid;
    d = p0_rdata;
  endtask

  task automatic p1_read(input logic [7:0] a, output logic [31:0] d, output logic lat_ok);
    p1_valid = 1'b1; p1_addr = a;
    wait_p1_ready("p1_rd_ready");
    tick();
    p1_valid = 1'b0;
    lat_ok = p1_rvalid;
    d = p1_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        ok;
    int          n;
    int          sent;
    int          nonzero;
    logic [31:0] got_q[$];

    rst0 = 1'b1; clear = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_wmask = 4'h0; p0_addr = 8'h00; p0_wdata = 32'h0;
    p0_rready = 1'b1; p1_valid = 1'b0; p1_addr = 8'h00; p1_rready = 1'b1;

    // Reset state and post-reset clear duration
    tick();
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    check_eq("rst_p0_rvalid", {31'd0, p0_rvalid}, 32'd0);
    check_eq("rst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    check_eq("rst_p0_rdata", p0_rdata, 32'h0);
    check_eq("rst_p1_rdata", p1_rdata, 32'h0);
    check_eq("rst_p0_ready", {31'd0, p0_ready}, 32'd0);
    rst0 = 1'b0;
    count_busy(n);
    check_eq("clear_len_reset", n, 256);
    check_eq("idle_p0_ready", {31'd0, p0_ready}, 32'd1);
    check_eq("idle_p1_ready", {31'd0, p1_ready}, 32'd1);
    repeat (20) tick();
    p1_read(8'hFF, d, ok);
    check_eq("p1_rd_ff_lat", {31'd0, ok}, 32'd1);
    check_eq("p1_rd_ff", d, 32'h0);

    // Full write then read
    p0_write(8'h10, 32'hDEADBEEF, 4'hF);
    p0_read(8'h10, d, ok);
    check_eq("p0_rd_lat", {31'd0, ok}, 32'd1);
    check_eq("p0_rd_10", d, 32'hDEADBEEF);

    // Masked write
    p0_write(8'h10, 32'h11223344, 4'b0101);
    p0_read(8'h10, d, ok);
    check_eq("p0_masked", d, 32'hDE22BE44);

    // Same-cycle p0 write and p1 read: p1 sees old data
    tick();
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 8'h20; p0_wdata = 32'hCAFEF00D; p0_wmask = 4'hF;
    p1_valid = 1'b1; p1_addr = 8'h20;
    check_eq("coll_rdy", {30'd0, p0_ready, p1_ready}, 32'd3);
    tick();
    p0_valid = 1'b0; p0_we = 1'b0; p1_valid = 1'b0;
    check_eq("coll_p1_rvalid", {31'd0, p1_rvalid}, 32'd1);
    check_eq("coll_p1_old", p1_rdata, 32'h0);
    tick();
    p1_read(8'h20, d, ok);
    check_eq("coll_p1_new", d, 32'hCAFEF00D);

    // Zero-mask write is a no-op
    p0_write(8'h20, 32'hFFFFFFFF, 4'h0);
    p0_read(8'h20, d, ok);
    check_eq("mask0_noop", d, 32'hCAFEF00D);

    // Both ports read the same word
    tick();
    p0_valid = 1'b1; p0_addr = 8'h20; p1_valid = 1'b1; p1_addr = 8'h20;
    tick();
    p0_valid = 1'b0; p1_valid = 1'b0;
    check_eq("dual_p0", p0_rdata, 32'hCAFEF00D);
    check_eq("dual_p1", p1_rdata, 32'hCAFEF00D);
    tick();

    // Port 1 backpressure with three in-order reads
    p0_write(8'h01, 32'h00000101, 4'hF);
    p0_write(8'h02, 32'h00000202, 4'hF);
    p0_write(8'h03, 32'h00000303, 4'hF);
    sent = 0;
    got_q.delete();
    for (int c = 0; c < 30 && got_q.size() < 3; c++) begin
      p1_rready = (c >= 4);
      p1_valid  = (sent < 3);
      p1_addr   = 8'(sent + 1);
      #1;
      if (c >= 1 && c <= 3) begin
        check_eq("bp_stall_ready", {31'd0, p1_ready}, 32'd0);
        check_eq("bp_stall_hold", p1_rdata, 32'h00000101);
      end
      if (p1_rvalid && p1_rready) got_q.push_back(p1_rdata);
      if (p1_valid && p1_ready) sent++;
      tick();
    end
    p1_valid = 1'b0;
    p1_rready = 1'b1;
    check_eq("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check_eq("bp_rsp0", got_q[0], 32'h00000101);
      check_eq("bp_rsp1", got_q[1], 32'h00000202);
      check_eq("bp_rsp2", got_q[2], 32'h00000303);
    end
    check_eq("bp_no_dup", {31'd0, p1_rvalid}, 32'd0);

    // Clear pulse while a port 0 response is stalled
    p0_write(8'h30, 32'h5A5A5A5A, 4'hF);
    p0_rready = 1'b0;
    p0_read(8'h30, d, ok);
    check_eq("stall_rd", d, 32'h5A5A5A5A);
    check_eq("stall_wr_blocked", {31'd0, p0_ready}, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    count_busy(n);
    check_eq("clear_len_pulse", n, 256);
    check_eq("stall_rvalid_held", {31'd0, p0_rvalid}, 32'd1);
    check_eq("stall_rdata_held", p0_rdata, 32'h5A5A5A5A);
    p0_rready = 1'b1;
    tick();
    check_eq("stall_drained", {31'd0, p0_rvalid}, 32'd0);
    nonzero = 0;
    for (int a = 0; a < 256; a++) begin
      p0_read(8'(a), d, ok);
      if (d !== 32'h0 || ok !== 1'b1) nonzero++;
    end
    check_eq("all_zero", nonzero, 0);

    // Reset in the middle of a clear, with a stalled port 1 response
    p0_write(8'h10, 32'h12345678, 4'hF);
    p1_rready = 1'b0;
    p1_read(8'h10, d, ok);
    check_eq("p1_stall_rd", d, 32'h12345678);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (100) tick();
    check_eq("midclr_busy", {31'd0, busy}, 32'd1);
    check_eq("midclr_p1_held", p1_rdata, 32'h12345678);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    check_eq("midrst_p1_rvalid", {31'd0, p1_rvalid}, 32'd0);
    check_eq("midrst_p1_rdata", p1_rdata, 32'h0);
    p1_rready = 1'b1;
    count_busy(n);
    check_eq("clear_len_midrst", n, 256);
    p1_read(8'h10, d, ok);
    check_eq("midrst_cleared", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_dual_port_ctrl.md
Name: sram_dual_port_ctrl

Overview:
- Parametrised, single-clock successor to the fixed 32x256 1rw1r SRAM wrapper.
- Holds a behavioural 1rw1r memory array of DEPTH = 2**ADDR_WIDTH words.
- Port 0 is read/write with per-byte write masking; port 1 is read-only.
- Both ports use active-high valid/ready request and response handshakes with backpressure.
- A built-in zero-fill (clear) sequencer runs after reset and on demand; the block sits between bus masters and on-chip storage.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, word address width; DEPTH = 2**ADDR_WIDTH.
- NUM_MASKS, DATA_WIDTH/8, number of byte-lane write-mask bits.

Ports:
- clk0  in  1  single clock; all logic on rising edge.
- rst0  in  1  synchronous, active-high reset.
- clear  in  1  single-cycle pulse; requests a zero-fill of the whole array.
- busy  out  1  high while the clear sequence runs.
- p0_valid  in  1  port 0 request valid.
- p0_ready  out  1  port 0 request accepted when valid && ready.
- p0_we  in  1  1 = write, 0 = read.
- p0_wmask  in  NUM_MASKS  byte-lane write enables; bit i covers data[8i+7:8i].
- p0_addr  in  ADDR_WIDTH  port 0 word address.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_rvalid  out  1  port 0 read response valid.
- p0_rready  in  1  port 0 response consumer ready.
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_valid  in  1  port 1 read request valid.
- p1_ready  out  1  port 1 request ready.
- p1_addr  in  ADDR_WIDTH  port 1 word address.
- p1_rvalid  out  1  port 1 read response valid.
- p1_rready  in  1  port 1 response consumer ready.
- p1_rdata  out  DATA_WIDTH  port 1 read data.

Behaviour:
- Reset (rst0 high at an edge):
  - state=CLEAR, clear address counter=0, busy=1.
  - p0_rvalid=p1_rvalid=0, p0_rdata=p1_rdata=0.
  - rst0 takes priority over every other input, including mid-clear; clear restarts from address 0.
- FSM states are CLEAR and IDLE.
- CLEAR:
  - Writes 0 to address cnt each cycle; cnt increments.
  - After the cycle that writes DEPTH-1, state=IDLE and busy=0. Total clear duration is DEPTH cycles.
  - The cnt wrap at DEPTH-1 must not re-enter CLEAR.
- IDLE:
  - clear=1 moves to CLEAR next cycle with cnt=0.
  - clear is ignored while already in CLEAR.
- Ready:
  - pN_ready = (state==IDLE) && !clear && (!pN_rvalid || pN_rready).
  - Combinational from state, clear and the response registers only; never from pN_valid.
  - For port 0, p0_ready also covers writes: a write is blocked while a port 0 read response is stalled.
- Port 0 write (accepted, p0_we=1):
  - Lanes with p0_wmask[i]=1 are updated at that edge; other lanes keep their value.
  - No response is generated; p0_rvalid is unchanged by the write.
  - p0_wmask=0 is a legal no-op write.
- Read (accepted, either port):
  - rdata is loaded with mem[addr] at the accept edge; rvalid=1 from the next cycle. Latency is 1.
  - rvalid and rdata hold stable until rvalid && rready.
  - Back-to-back reads at 1/cycle are sustained while rready=1: accept and consume in the same cycle.
  - When a response is consumed and no new read is accepted, rvalid goes to 0; rdata may hold.
- Collisions:
  - p0 write and p1 read to the same address in the same cycle: p1 returns the pre-write data (read-before-write).
  - p0 read after a p0 write to the same address in the next cycle returns the new data.
  - Both ports reading the same address is legal; both return identical data.
- Clear with a response pending: a stalled rvalid/rdata is held across CLEAR and drains normally. rdata is not zeroed by clear.
- Requests presented while busy are not accepted; the master holds valid.

Test Plan:
- Reset, idle 300 cycles (DEPTH=256): busy is high for exactly 256 cycles then low; p0_ready rises on the first IDLE cycle; p1 read of addr 0xFF returns 0x00000000.
- p0 write addr 0x10 data 0xDEADBEEF mask 0xF, then p0 read 0x10: p0_rvalid one cycle after accept, p0_rdata=0xDEADBEEF.
- Masked write to 0x10 with data 0x11223344, mask 0b0101, then read: 0xDE22BE44.
- Same cycle: p0 write 0x20=0xCAFEF00D and p1 read 0x20 (previously 0): p1_rdata=0; a following p1 read of 0x20 returns 0xCAFEF00D.
- Backpressure: p1 reads of addrs 1,2,3 every cycle with p1_rready low for 3 cycles: p1_ready=0 while stalled, rdata held, no response lost or duplicated, 3 responses delivered in order.
- Mid-operation events:
  - clear pulse with a port 0 response stalled: response still delivered intact, busy high for 256 cycles, all words read back 0.
  - rst0 asserted at cnt=100: the next clear runs a full 256 cycles.
